// File: rtl/alu_pkg.sv
// Shared ALU constants, opcode names and the response record used by issue,
// decode and writeback.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned ALU_TAG_W  = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOR   = 4'd5,
    OP_SLL   = 4'd6,
    OP_SRL   = 4'd7,
    OP_SRA   = 4'd8,
    OP_SLT   = 4'd9,
    OP_SLTU  = 4'd10,
    OP_PASSB = 4'd11
  } alu_op_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  equal;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_rsp_t;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Request and response valid/ready channels between issue logic and the ALU front end.
interface alu_issue_unit_if #(
  parameter int unsigned DATA_W = alu_pkg::ALU_DATA_W,
  parameter int unsigned OP_W   = alu_pkg::ALU_OP_W,
  parameter int unsigned TAG_W  = alu_pkg::ALU_TAG_W
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [OP_W-1:0]   req_op;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_equal;
  logic [TAG_W-1:0]  rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_equal, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_equal, rsp_tag
  );
endinterface

// File: rtl/alu.sv
// Combinational ALU: result from operands X, Y under select S, plus X==Y flag.
module alu import alu_pkg::*; #(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned OP_W   = ALU_OP_W
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [OP_W-1:0]   s_i,
  output logic [DATA_W-1:0] result_o,
  output logic              equal_o
);
  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  assign sh = y_i[SH_W-1:0];

  always_comb begin
    result_o = '0;
    case (s_i)
      OP_ADD:   result_o = x_i + y_i;
      OP_SUB:   result_o = x_i - y_i;
      OP_AND:   result_o = x_i & y_i;
      OP_OR:    result_o = x_i | y_i;
      OP_XOR:   result_o = x_i ^ y_i;
      OP_NOR:   result_o = ~(x_i | y_i);
      OP_SLL:   result_o = x_i << sh;
      OP_SRL:   result_o = x_i >> sh;
      OP_SRA:   result_o = $signed(x_i) >>> sh;
      OP_SLT:   result_o = DATA_W'($signed(x_i) < $signed(y_i));
      OP_SLTU:  result_o = DATA_W'(x_i < y_i);
      OP_PASSB: result_o = y_i;
      default:  result_o = '0;
    endcase
  end

  assign equal_o = (x_i == y_i);
endmodule

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; clr_i empties it on the next edge.
module alu_rsp_fifo import alu_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = alu_rsp_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/alu_issue_unit.sv
// ALU front end: one register stage into the ALU, credit-based back-pressure,
// and an in-order tagged response FIFO.
module alu_issue_unit import alu_pkg::*; #(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned OP_W   = ALU_OP_W,
  parameter int unsigned TAG_W  = ALU_TAG_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  alu_issue_unit_if.slave     bus,
  output logic [31:0]         op_count
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              equal;
    logic [TAG_W-1:0]  tag;
  } rsp_t;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  logic [OP_W-1:0]   s1_op_q, s1_op_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [31:0]       op_count_q, op_count_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              accept, push, pop;
  logic [DATA_W-1:0] alu_result;
  logic              alu_equal;
  rsp_t              push_data, head;

  // Stage plus FIFO never exceeds DEPTH, so a push always finds a free slot.
  assign occupancy     = {1'b0, fifo_count} + (CNT_W+1)'(s1_valid_q);
  assign bus.req_ready = occupancy < (CNT_W+1)'(DEPTH);
  assign bus.rsp_valid = (fifo_count != '0);

  assign accept = bus.req_valid && bus.req_ready;
  assign push   = s1_valid_q && !flush;
  assign pop    = bus.rsp_valid && bus.rsp_ready && !flush;

  always_comb begin
    s1_valid_d = accept && !flush;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    if (accept) begin
      s1_a_d   = bus.req_a;
      s1_b_d   = bus.req_b;
      s1_op_d  = bus.req_op;
      s1_tag_d = bus.req_tag;
    end
    op_count_d = op_count_q + 32'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      op_count_q <= op_count_d;
    end
  end

  alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .x_i      (s1_a_q),
    .y_i      (s1_b_q),
    .s_i      (s1_op_q),
    .result_o (alu_result),
    .equal_o  (alu_equal)
  );

  assign push_data = '{result: alu_result, equal: alu_equal, tag: s1_tag_q};

  alu_rsp_fifo #(
    .DEPTH (DEPTH),
    .T     (rsp_t)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (flush),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_count)
  );

  assign bus.rsp_result = head.result;
  assign bus.rsp_equal  = head.equal;
  assign bus.rsp_tag    = head.tag;
  assign op_count       = op_count_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: randomized traffic against a queue-based reference model.
module tb_alu_issue_unit;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;
  localparam int unsigned TW = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] op_count;
  int          checks = 0;
  int          errors = 0;

  alu_issue_unit_if #(.DATA_W(DW), .OP_W(OW), .TAG_W(TW)) bus ();

  alu_issue_unit #(.DATA_W(DW), .OP_W(OW), .TAG_W(TW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic        equal;
    logic [3:0]  tag;
    int          vis;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  logic [31:0] exp_ops = '0;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return $signed(a) >>> b[4:0];
      4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10:   return (a < b) ? 32'd1 : 32'd0;
      4'd11:   return b;
      default: return 32'd0;
    endcase
  endfunction

  // Outstanding ops = accepted minus returned; an op is visible two edges after its request.
  function automatic bit m_ready();
    return exp_q.size() < int'(DEPTH);
  endfunction

  function automatic bit m_valid();
    return (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
  endfunction

  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [3:0] tag, input bit rr, input bit fl);
    bit   acc;
    bit   pp;
    exp_t e;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_tag   = tag;
    bus.rsp_ready = rr;
    flush         = fl;
    acc = v && m_ready();
    pp  = rr && m_valid();
    @(posedge clk);
    cyc++;
    if (fl) exp_q.delete();
    else begin
      if (pp) begin
        void'(exp_q.pop_front());
        exp_ops++;
      end
      if (acc) begin
        e.result = alu_ref(a, b, op);
        e.equal  = (a == b);
        e.tag    = tag;
        e.vis    = cyc + 1;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_result !== 32'd0) begin errors++; $display("FAIL reset_rsp_result got %0h want 0", bus.rsp_result); end
    checks++; if (bus.rsp_equal !== 1'b0) begin errors++; $display("FAIL reset_rsp_equal got %0b want 0", bus.rsp_equal); end
    checks++; if (bus.rsp_tag !== 4'd0) begin errors++; $display("FAIL reset_rsp_tag got %0h want 0", bus.rsp_tag); end
    checks++; if (op_count !== 32'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
  endtask

  task automatic test_single();
    step(1'b1, 32'd11, 32'd3, 4'd0, 4'd5, 1'b0, 1'b0);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", bus.rsp_valid); end
    step(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_result !== alu_ref(32'd11, 32'd3, 4'd0)) begin errors++; $display("FAIL single_result got %0d want %0d", bus.rsp_result, alu_ref(32'd11, 32'd3, 4'd0)); end
    checks++; if (bus.rsp_equal !== 1'b0) begin errors++; $display("FAIL single_equal got %0b want 0", bus.rsp_equal); end
    checks++; if (bus.rsp_tag !== 4'd5) begin errors++; $display("FAIL single_tag got %0d want 5", bus.rsp_tag); end
    step(1'b0, '0, '0, 4'd0, 4'd0, 1'b1, 1'b0);
    checks++; if (op_count !== 32'd1) begin errors++; $display("FAIL single_op_count got %0d want 1", op_count); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_equal();
    logic eq_exp [2];
    logic [3:0] tg_exp [2];
    int k = 0;
    eq_exp[0] = 1'b1; eq_exp[1] = 1'b0;
    tg_exp[0] = 4'd1; tg_exp[1] = 4'd2;
    step(1'b1, 32'd9, 32'd9, 4'd0, 4'd1, 1'b1, 1'b0);
    step(1'b1, 32'd9, 32'd3, 4'd0, 4'd2, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      if (bus.rsp_valid === 1'b1) begin
        if (k < 2) begin
          checks++; if (bus.rsp_equal !== eq_exp[k]) begin errors++; $display("FAIL equal_flag[%0d] got %0b want %0b", k, bus.rsp_equal, eq_exp[k]); end
          checks++; if (bus.rsp_tag !== tg_exp[k]) begin errors++; $display("FAIL equal_tag[%0d] got %0d want %0d", k, bus.rsp_tag, tg_exp[k]); end
        end
        k++;
      end
      step(1'b0, '0, '0, 4'd0, 4'd0, 1'b1, 1'b0);
    end
    checks++; if (k != 2) begin errors++; $display("FAIL equal_count got %0d want 2", k); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] ra [6];
    logic [31:0] rb [6];
    logic [3:0]  rop [6];
    int i = 0;
    int got = 0;
    bit obs;
    bit v;
    for (int n = 0; n < 6; n++) begin
      ra[n]  = $urandom;
      rb[n]  = $urandom;
      rop[n] = 4'($urandom_range(0, 11));
    end
    for (int c = 0; c < 8; c++) begin
      checks++; if (bus.req_ready !== m_ready()) begin errors++; $display("FAIL bp_ready c%0d got %0b want %0b", c, bus.req_ready, m_ready()); end
      obs = bus.req_ready;
      step(1'b1, ra[i], rb[i], rop[i], 4'(i), 1'b0, 1'b0);
      if (obs) i++;
    end
    checks++; if (i != 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", i); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b want 0", bus.req_ready); end
    for (int c = 0; c < 20 && (got < 6 || i < 6); c++) begin
      checks++; if (bus.req_ready !== m_ready()) begin errors++; $display("FAIL bp_drain_ready c%0d got %0b want %0b", c, bus.req_ready, m_ready()); end
      if (bus.rsp_valid === 1'b1) begin
        if (got < 6) begin
          checks++; if (bus.rsp_tag !== 4'(got)) begin errors++; $display("FAIL bp_order got %0d want %0d", bus.rsp_tag, got); end
          checks++; if (bus.rsp_result !== alu_ref(ra[got], rb[got], rop[got])) begin errors++; $display("FAIL bp_result[%0d] got %0h want %0h", got, bus.rsp_result, alu_ref(ra[got], rb[got], rop[got])); end
        end
        got++;
      end
      v   = (i < 6);
      obs = bus.req_ready;
      if (v) step(1'b1, ra[i], rb[i], rop[i], 4'(i), 1'b1, 1'b0);
      else   step(1'b0, '0, '0, 4'd0, 4'd0, 1'b1, 1'b0);
      if (v && obs) i++;
    end
    checks++; if (i != 6) begin errors++; $display("FAIL bp_total_accepted got %0d want 6", i); end
    checks++; if (got != 6) begin errors++; $display("FAIL bp_total_returned got %0d want 6", got); end
  endtask

  task automatic test_streaming();
    logic [3:0]  opset [4];
    logic [31:0] ops0;
    logic [31:0] a;
    logic [31:0] b;
    int npop = 0;
    opset[0] = 4'd11; opset[1] = 4'd0; opset[2] = 4'd1; opset[3] = 4'd2;
    ops0 = exp_ops;
    for (int c = 0; c < 102; c++) begin
      if (c < 100) begin
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready c%0d got %0b want 1", c, bus.req_ready); end
      end
      checks++; if (bus.rsp_valid !== m_valid()) begin errors++; $display("FAIL stream_valid c%0d got %0b want %0b", c, bus.rsp_valid, m_valid()); end
      if (m_valid()) begin
        checks++; if (bus.rsp_result !== exp_q[0].result) begin errors++; $display("FAIL stream_result c%0d got %0h want %0h", c, bus.rsp_result, exp_q[0].result); end
        checks++; if (bus.rsp_equal !== exp_q[0].equal) begin errors++; $display("FAIL stream_equal c%0d got %0b want %0b", c, bus.rsp_equal, exp_q[0].equal); end
        checks++; if (bus.rsp_tag !== exp_q[0].tag) begin errors++; $display("FAIL stream_tag c%0d got %0h want %0h", c, bus.rsp_tag, exp_q[0].tag); end
      end
      if (bus.rsp_valid === 1'b1) npop++;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      step(c < 100, a, b, opset[$urandom_range(0, 3)], 4'($urandom), 1'b1, 1'b0);
    end
    checks++; if (npop != 100) begin errors++; $display("FAIL stream_responses got %0d want 100", npop); end
    checks++; if (op_count !== ops0 + 32'd100) begin errors++; $display("FAIL stream_op_count got %0d want %0d", op_count, ops0 + 32'd100); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_flush();
    int n = 0;
    for (int c = 0; c < 4; c++) step(1'b1, $urandom, $urandom, 4'($urandom_range(0, 11)), 4'(c), 1'b0, 1'b0);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_ready got %0b want 0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %0b want 1", bus.rsp_valid); end
    step(1'b1, 32'd5, 32'd6, 4'd0, 4'd3, 1'b1, 1'b1);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", bus.rsp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", bus.req_ready); end
    checks++; if (op_count !== exp_ops) begin errors++; $display("FAIL flush_op_count got %0d want %0d", op_count, exp_ops); end
    step(1'b1, 32'd100, 32'd42, 4'd1, 4'd7, 1'b0, 1'b0);
    step(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_after_valid got %0b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_tag !== 4'd7) begin errors++; $display("FAIL flush_after_tag got %0d want 7", bus.rsp_tag); end
    checks++; if (bus.rsp_result !== 32'd58) begin errors++; $display("FAIL flush_after_result got %0d want 58", bus.rsp_result); end
    for (int c = 0; c < 4; c++) begin
      if (bus.rsp_valid === 1'b1) n++;
      step(1'b0, '0, '0, 4'd0, 4'd0, 1'b1, 1'b0);
    end
    checks++; if (n != 1) begin errors++; $display("FAIL flush_alone got %0d responses want 1", n); end
    checks++; if (op_count !== exp_ops) begin errors++; $display("FAIL flush_final_count got %0d want %0d", op_count, exp_ops); end
  endtask

  task automatic test_reset_mid();
    int npop = 0;
    for (int c = 0; c < 3; c++) step(1'b1, $urandom, $urandom, 4'($urandom_range(0, 11)), 4'(c + 8), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b want 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_result !== 32'd0) begin errors++; $display("FAIL rstmid_result got %0h want 0", bus.rsp_result); end
    checks++; if (bus.rsp_tag !== 4'd0) begin errors++; $display("FAIL rstmid_tag got %0h want 0", bus.rsp_tag); end
    checks++; if (op_count !== 32'd0) begin errors++; $display("FAIL rstmid_op_count got %0d want 0", op_count); end
    exp_q.delete();
    exp_ops = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      checks++; if (bus.rsp_valid !== m_valid()) begin errors++; $display("FAIL resume_valid c%0d got %0b want %0b", c, bus.rsp_valid, m_valid()); end
      if (m_valid()) begin
        checks++; if (bus.rsp_result !== exp_q[0].result) begin errors++; $display("FAIL resume_result c%0d got %0h want %0h", c, bus.rsp_result, exp_q[0].result); end
        checks++; if (bus.rsp_tag !== exp_q[0].tag) begin errors++; $display("FAIL resume_tag c%0d got %0h want %0h", c, bus.rsp_tag, exp_q[0].tag); end
      end
      if (bus.rsp_valid === 1'b1) npop++;
      step(c < 10, $urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom), 1'b1, 1'b0);
    end
    checks++; if (npop != 10) begin errors++; $display("FAIL resume_responses got %0d want 10", npop); end
    checks++; if (op_count !== 32'd10) begin errors++; $display("FAIL resume_op_count got %0d want 10", op_count); end
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single();
    test_equal();
    test_back_pressure();
    test_streaming();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
